// File: rtl/esp8266_pkg.sv
// Shared types and helpers for the ESP8266 UART transmit path.
package esp8266_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    // Clock cycles per bit; integer division, truncating.
    function automatic int unsigned baud_div(input int unsigned clk, input int unsigned baud);
        return clk / baud;
    endfunction

endpackage

// File: rtl/esp8266_uart_tx_if.sv
// Encoder-to-UART byte strobe plus line and status signals.
interface esp8266_uart_tx_if;
    import esp8266_pkg::*;

    logic                 Sig;
    logic [DATA_BITS-1:0] Data_send;
    logic                 Tx;
    logic                 Tx_busy;
    logic                 Tx_done;
    logic                 Fifo_full;
    logic                 Overflow;

    modport master (
        output Sig,
        output Data_send,
        input  Tx,
        input  Tx_busy,
        input  Tx_done,
        input  Fifo_full,
        input  Overflow
    );

    modport slave (
        input  Sig,
        input  Data_send,
        output Tx,
        output Tx_busy,
        output Tx_done,
        output Fifo_full,
        output Overflow
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous circular FIFO with registered full/empty/count flags.
module uart_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rd_data_c,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;
    logic             w_do_push;
    logic             w_do_pop;
    logic [CW-1:0]    w_count_next;

    assign w_do_push = i_push & ~r_full;
    assign w_do_pop  = i_pop & ~r_empty;

    // Simultaneous push and pop leaves the occupancy unchanged.
    always_comb begin
        w_count_next = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_do_push && w_do_pop) begin
            w_count_next = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CW'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_rd_data_c = r_mem[r_rd_ptr];
    assign o_full      = r_full;
    assign o_empty     = r_empty;
    assign o_count     = r_count;

endmodule

// File: rtl/esp8266_uart_tx.sv
// Buffers encoder bytes captured on Sig falling edges and sends them as 8N1 frames.
// Define UART_PARITY_EN to insert an even-parity bit (8E1).
module esp8266_uart_tx
    import esp8266_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    esp8266_uart_tx_if.slave bus
);

    localparam int unsigned BAUD_DIV      = baud_div(CLK_FREQ, BAUD);
    localparam int unsigned CNT_W         = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned CW            = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned IDX_W         = $clog2(DATA_BITS);
    localparam bit          ONE_CYCLE_BIT = (BAUD_DIV == 1);
    localparam int unsigned PRE_LAST      = ONE_CYCLE_BIT ? 0 : BAUD_DIV - 2;

    logic                 r_sig_d;
    logic                 r_overflow;
    state_e               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_sh;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_done;
`ifdef UART_PARITY_EN
    logic                 r_par;
`endif

    logic                 w_fall;
    logic                 w_drop;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_bit_end;
    logic                 w_last_bit;
    logic                 w_stop_pre;
    logic [DATA_BITS-1:0] w_rd_data;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [CW-1:0]        w_fifo_count;

    // Falling-edge detector on the encoder strobe.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_sig_d <= 1'b0;
        end else begin
            r_sig_d <= bus.Sig;
        end
    end

    assign w_fall = r_sig_d & ~bus.Sig;
    assign w_drop = w_fall & (w_fifo_count == CW'(FIFO_DEPTH));
    assign w_push = w_fall & ~w_drop;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (Clk),
        .rst_n       (Rst_n),
        .i_push      (w_push),
        .i_data      (bus.Data_send),
        .i_pop       (w_pop),
        .o_rd_data_c (w_rd_data),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    assign w_pop      = (r_state == IDLE) & ~w_fifo_empty;
    assign w_bit_end  = (r_cnt == CNT_W'(BAUD_DIV - 1));
    assign w_last_bit = (r_idx == IDX_W'(DATA_BITS - 1));
    assign w_stop_pre = ~ONE_CYCLE_BIT & (r_cnt == CNT_W'(PRE_LAST));

    // Frame sequencer; Tx, Tx_busy and Tx_done are registered from the next state.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_sh    <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef UART_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (w_pop) begin
                        r_sh    <= w_rd_data;
`ifdef UART_PARITY_EN
                        r_par   <= ^w_rd_data;
`endif
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= START;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= DATA;
                        r_tx    <= r_sh[0];
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (w_last_bit) begin
`ifdef UART_PARITY_EN
                            r_state <= PARITY;
                            r_tx    <= r_par;
`else
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                            r_done  <= ONE_CYCLE_BIT;
`endif
                        end else begin
                            r_sh  <= r_sh >> 1;
                            r_tx  <= r_sh[1];
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                        r_done  <= ONE_CYCLE_BIT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    // Raise Tx_done so it lands on the final stop-bit cycle.
                    r_done <= w_stop_pre;
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Tx        = r_tx;
    assign bus.Tx_busy   = r_busy;
    assign bus.Tx_done   = r_done;
    assign bus.Fifo_full = w_fifo_full;
    assign bus.Overflow  = r_overflow;

endmodule

// File: doc/esp8266_uart_tx.md
Name: esp8266_uart_tx

Overview:
Serialises the byte stream produced by the ESP8266 command encoder into 8N1 UART frames on the line to the ESP8266 module.
- Upstream encoder presents one byte per Sig pulse on Data_send.
- This block captures each byte on the falling edge of Sig and buffers it in a small FIFO.
- Bytes are transmitted LSB-first at a fixed baud rate derived from the system clock.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD, 115200: line rate in bit/s. BAUD_DIV = CLK_FREQ/BAUD, integer division (434 at default).
- FIFO_DEPTH, 16: byte buffer depth; must be a power of 2, minimum 2.

Ports:
- Clk, input, 1: system clock; all logic is on the rising edge.
- Rst_n, input, 1: asynchronous active-low reset.
- Sig, input, 1: byte strobe from the encoder, same clock domain, level signal.
- Data_send, input, 8: byte from the encoder; stable when Sig falls.
- Tx, output, 1: UART line to the ESP8266 RX pin; idles high.
- Tx_busy, output, 1: high while a frame is on the line (START through STOP).
- Tx_done, output, 1: one-cycle pulse on the last cycle of each stop bit.
- Fifo_full, output, 1: FIFO count equals FIFO_DEPTH.
- Overflow, output, 1: sticky; set when a capture is dropped; cleared only by reset.

Behaviour:
- Reset values: Tx=1, Tx_busy=0, Tx_done=0, Fifo_full=0, Overflow=0, FIFO empty, FSM in IDLE, baud counter 0, edge register 0.
- Capture:
  - sig_d registers Sig.
  - Falling edge = sig_d & ~Sig, detected in cycle N.
  - Data_send is written into the FIFO at the clock edge ending cycle N.
  - If the FIFO is full, the byte is dropped and Overflow is set at the same edge.
  - A rising edge of Sig has no effect.
- FIFO:
  - Circular buffer with wrapping read/write pointers and a count from 0 to FIFO_DEPTH.
  - Push and pop in the same cycle leave the count unchanged.
  - Push when full is ignored; pop is issued only when the FIFO is non-empty.
- FSM states: IDLE, START, DATA, STOP (plus PARITY under the optional feature).
  - IDLE: Tx=1. If the FIFO is non-empty, pop into shift register sh, clear the baud counter, bit index=0, go to START. Tx goes low on the cycle after the byte is written, i.e. 2 cycles after the Sig falling edge when idle.
  - START: Tx=0 for BAUD_DIV cycles, then go to DATA.
  - DATA: Tx=sh[0]. Every BAUD_DIV cycles, shift sh right and increment the index. After the 8th bit, go to STOP.
  - STOP: Tx=1 for BAUD_DIV cycles. Tx_done is asserted on the final cycle. Next state is IDLE; a queued byte starts its START bit on the following cycle, so the inter-frame gap is 1 cycle.
- Baud counter counts 0..BAUD_DIV-1 and reloads to 0 at each bit boundary.
- Tx is registered (glitch-free) and driven from the FSM state and sh.
- Tx_busy=1 in every state except IDLE.
- Reset mid-frame: Tx returns to 1 immediately; FIFO contents and the frame in progress are discarded.
- A Sig falling edge during an active frame only enqueues; it never disturbs the current frame.

Optional Feature:
- Macro: UART_PARITY_EN.
  - Defined: a PARITY state between DATA and STOP drives the even-parity bit (XOR of the 8 data bits, latched at pop) for BAUD_DIV cycles. Frame is 11 bits (8E1).
  - Undefined: no PARITY state; frame is 10 bits (8N1).

Decomposition:
- Package esp8266_pkg holds:
  - state enum: IDLE, START, DATA, PARITY, STOP;
  - function baud_div(clk, baud);
  - constant DATA_BITS=8.
- Sub-module uart_tx_fifo: parameterised synchronous FIFO with push/pop/full/empty/count, instanced once.

Test Plan:
All tests use CLK_FREQ=1000000 and BAUD=100000, so BAUD_DIV=10.
- Single byte: one Sig pulse with Data_send=0x6D.
  - Tx falls 2 cycles after Sig falls.
  - Bit sequence 0,1,0,1,1,0,1,1,0,1, each bit 10 cycles.
  - Tx_done pulses at cycle 100 of the frame; Tx_busy is high for exactly 100 cycles.
- Burst: 16 pulses 3 cycles apart (bytes "m(\"T\",\"12.5\")\r\n\n").
  - All 16 frames appear back-to-back with a 1-cycle gap; decoded bytes match in order.
  - Overflow stays 0.
- Overflow: 18 pulses 3 cycles apart with bytes 0x00..0x11.
  - Fifo_full is observed.
  - Byte 0x00 is popped immediately, so exactly one byte (0x11) is dropped and Overflow=1.
  - Decoded output is 0x00..0x10.
- Reset mid-frame: assert Rst_n=0 during DATA bit 3.
  - Tx=1 in the same cycle; all other outputs return to reset values.
  - No further frames after release until a new Sig pulse.
- Edge rules: hold Sig high for 200 cycles -> no frame until Sig falls. A rising edge alone produces nothing.
- Parity (UART_PARITY_EN): byte 0x07 gives parity bit 1 and an 11-bit frame; Tx_done pulses at cycle 110.
